// File: rtl/pcie_rx_sink.sv
// Receive sink: round-robin pops from the D0/D1 output FIFOs, presents one word at a time
// downstream with per-source delivery counts. Optional route check: RX_SINK_ROUTE_CHECK_EN.
module pcie_rx_sink #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              src_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  count_D0,
  output logic [CNT_W-1:0]  count_D1,
  output logic              idle_out,
  output logic              error_out
);

  localparam int ROUTE_BIT = 4;

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t            state;
  logic              last_src;
  logic              sel_src;
  logic              pick_vld;
  logic              pick_src;
  logic              issue;
  logic [DATA_W-1:0] cap_word;

  // Arbitration and the pop decision are made from the current inputs; pops are registered.
  always_comb begin
    pick_vld = enable && (!empty_D0 || !empty_D1);
    pick_src = (!empty_D0 && !empty_D1) ? ~last_src : empty_D0;
    issue    = pick_vld && ((state == IDLE) || ((state == OUT) && ready_in));
    cap_word = sel_src ? data_in1 : data_in0;
  end

  always_ff @(posedge clk) begin
    if (reset_L) begin
      state     <= IDLE;
      pop_D0    <= 1'b0;
      pop_D1    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      src_out   <= 1'b0;
      count_D0  <= '0;
      count_D1  <= '0;
      idle_out  <= 1'b0;
      last_src  <= 1'b1;
      sel_src   <= 1'b0;
    end else begin
      pop_D0   <= issue && !pick_src;
      pop_D1   <= issue && pick_src;
      idle_out <= (state == IDLE) && empty_D0 && empty_D1;
      if (issue) begin
        sel_src  <= pick_src;
        last_src <= pick_src;
      end
      case (state)
        IDLE: if (issue) state <= RD;
        RD:   state <= CAP;
        CAP: begin
          data_out  <= cap_word;
          src_out   <= sel_src;
          valid_out <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          // A held word waits here; acceptance may chain straight into the next pop.
          if (ready_in) begin
            valid_out <= 1'b0;
            if (src_out) count_D1 <= count_D1 + CNT_W'(1);
            else         count_D0 <= count_D0 + CNT_W'(1);
            state <= issue ? RD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RX_SINK_ROUTE_CHECK_EN
  logic route_err;

  always_ff @(posedge clk) begin
    if (reset_L) begin
      route_err <= 1'b0;
    end else if ((state == CAP) && (cap_word[ROUTE_BIT] != sel_src)) begin
      route_err <= 1'b1;
    end
  end

  assign error_out = route_err;
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_rx_sink.sv
// Randomized bench for pcie_rx_sink: FIFO models plus a transaction-level reference
// (one outstanding word, round-robin source choice, 2-cycle pop-to-valid latency).
module tb_pcie_rx_sink;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       enable = 1'b0;
  logic       empty_D0 = 1'b1;
  logic       empty_D1 = 1'b1;
  logic [5:0] data_in0 = '0;
  logic [5:0] data_in1 = '0;
  logic       pop_D0, pop_D1;
  logic [5:0] data_out;
  logic       valid_out;
  logic       src_out;
  logic       ready_in = 1'b0;
  logic [7:0] count_D0, count_D1;
  logic       idle_out;
  logic       error_out;

  always #5 clk = ~clk;

  pcie_rx_sink dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .enable    (enable),
    .empty_D0  (empty_D0),
    .empty_D1  (empty_D1),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .pop_D0    (pop_D0),
    .pop_D1    (pop_D1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .src_out   (src_out),
    .ready_in  (ready_in),
    .count_D0  (count_D0),
    .count_D1  (count_D1),
    .idle_out  (idle_out),
    .error_out (error_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic       inflight = 1'b0;
  logic [5:0] inf_word = '0;
  logic       inf_src = 1'b0;
  int         inf_age = 0;
  logic       m_last = 1'b1;
  logic [7:0] m_cnt0 = '0;
  logic [7:0] m_cnt1 = '0;
  logic       m_err = 1'b0;
  logic       prev_can_pop = 1'b0;
  logic       prev_idle = 1'b0;
  logic       prev_ne0 = 1'b0;
  logic       prev_ne1 = 1'b0;
  logic       post_rst = 1'b0;
  logic       armed = 1'b0;
  logic       bad_en = 1'b0;

  function automatic logic [5:0] mkword(input logic s, input logic bad);
    logic [5:0] w;
    w    = 6'($urandom);
    w[4] = s ^ (bad && ($urandom % 4 == 0));
    return w;
  endfunction

  // rst_mode: 0 none, 1 reset now, 2 reset in the cycle a pop is seen, 3 random 1% reset
  task automatic tick(input int en_pct, input int rdy_pct, input int push0_pct,
                      input int push1_pct, input int rst_mode);
    logic       s, exp_s, exp_v, idle_now, rst, popped;
    logic [5:0] w;
    @(negedge clk);
    popped = (pop_D0 === 1'b1) || (pop_D1 === 1'b1);
    if (armed) begin
      check_eq("pop_excl", {31'd0, pop_D0 & pop_D1}, 32'd0);
      check_eq("pop_issue", {31'd0, popped}, {31'd0, prev_can_pop});
    end
    if (popped) begin
      s     = (pop_D1 === 1'b1);
      exp_s = (prev_ne0 && prev_ne1) ? ~m_last : prev_ne1;
      if (armed) begin
        check_eq("rr_src", {31'd0, s}, {31'd0, exp_s});
        check_eq("pop_nonempty", {31'd0, s ? prev_ne1 : prev_ne0}, 32'd1);
      end
      m_last = s;
      w = 6'h0;
      if (s) begin
        if (q1.size() > 0) w = q1.pop_front();
        data_in1 = w;
      end else begin
        if (q0.size() > 0) w = q0.pop_front();
        data_in0 = w;
      end
      inflight = 1'b1;
      inf_word = w;
      inf_src  = s;
      inf_age  = 0;
    end else if (inflight) begin
      inf_age++;
    end
    exp_v = inflight && (inf_age >= 2);
    if (armed) begin
      check_eq("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
      if (exp_v) begin
        check_eq("data_out", {26'd0, data_out}, {26'd0, inf_word});
        check_eq("src_out", {31'd0, src_out}, {31'd0, inf_src});
`ifdef RX_SINK_ROUTE_CHECK_EN
        if (inf_word[4] != inf_src) m_err = 1'b1;
`endif
      end
      if (post_rst) begin
        check_eq("rst_data", {26'd0, data_out}, 32'd0);
        check_eq("rst_src", {31'd0, src_out}, 32'd0);
      end
      check_eq("error_out", {31'd0, error_out}, {31'd0, m_err});
      check_eq("count_D0", {24'd0, count_D0}, {24'd0, m_cnt0});
      check_eq("count_D1", {24'd0, count_D1}, {24'd0, m_cnt1});
      check_eq("idle_out", {31'd0, idle_out}, {31'd0, prev_idle});
    end
    post_rst = 1'b0;
    idle_now = !inflight;

    // Drive the inputs seen at the next rising edge
    if (($urandom % 100) < push0_pct) q0.push_back(mkword(1'b0, bad_en));
    if (($urandom % 100) < push1_pct) q1.push_back(mkword(1'b1, bad_en));
    enable   = (($urandom % 100) < en_pct);
    ready_in = (($urandom % 100) < rdy_pct);
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
    rst = (rst_mode == 1) || ((rst_mode == 2) && popped) ||
          ((rst_mode == 3) && ($urandom % 100 == 0));
    reset_L = rst;

    if (rst) begin
      inflight     = 1'b0;
      m_cnt0       = '0;
      m_cnt1       = '0;
      m_last       = 1'b1;
      m_err        = 1'b0;
      prev_can_pop = 1'b0;
      prev_idle    = 1'b0;
      post_rst     = 1'b1;
    end else begin
      if (exp_v && ready_in) begin
        if (inf_src) m_cnt1 = m_cnt1 + 8'd1;
        else         m_cnt0 = m_cnt0 + 8'd1;
        inflight = 1'b0;
      end
      prev_can_pop = enable && (!empty_D0 || !empty_D1) && !inflight;
      prev_idle    = idle_now && empty_D0 && empty_D1;
    end
    prev_ne0 = !empty_D0;
    prev_ne1 = !empty_D1;
    armed    = 1'b1;
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    tick(100, 100, 0, 0, 1);
  endtask

  logic exp_err;

  initial begin
    // Reset, then quiet FIFOs: nothing popped, idle from the second cycle
    do_reset();
    repeat (10) tick(100, 100, 0, 0, 0);
    check_eq("s1_idle", {31'd0, idle_out}, 32'd1);
    check_eq("s1_valid", {31'd0, valid_out}, 32'd0);

    // Single D0 word
    do_reset();
    q0.push_back(6'h05);
    repeat (8) tick(100, 100, 0, 0, 0);
    check_eq("s2_cnt0", {24'd0, count_D0}, 32'd1);
    check_eq("s2_data", {26'd0, data_out}, 32'h05);

    // Three words each side, alternating service
    do_reset();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mkword(1'b0, 1'b0));
      q1.push_back(mkword(1'b1, 1'b0));
    end
    repeat (25) tick(100, 100, 0, 0, 0);
    check_eq("s3_cnt0", {24'd0, count_D0}, 32'd3);
    check_eq("s3_cnt1", {24'd0, count_D1}, 32'd3);

    // Backpressure on a held word
    do_reset();
    q1.push_back(6'h1a);
    repeat (9) tick(100, 0, 0, 0, 0);
    check_eq("s4_hold_cnt", {24'd0, count_D1}, 32'd0);
    check_eq("s4_hold_data", {26'd0, data_out}, 32'h1a);
    repeat (3) tick(100, 100, 0, 0, 0);
    check_eq("s4_cnt1", {24'd0, count_D1}, 32'd1);

    // Misrouted D0 word
    do_reset();
    q0.push_back(6'h12);
    repeat (8) tick(100, 100, 0, 0, 0);
`ifdef RX_SINK_ROUTE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check_eq("s5_err", {31'd0, error_out}, {31'd0, exp_err});
    check_eq("s5_cnt0", {24'd0, count_D0}, 32'd1);
    repeat (4) tick(100, 100, 0, 0, 0);
    check_eq("s5_err_sticky", {31'd0, error_out}, {31'd0, exp_err});

    // D1 counter wrap
    do_reset();
    for (int i = 0; i < 255; i++) q1.push_back(mkword(1'b1, 1'b0));
    repeat (255 * 3 + 6) tick(100, 100, 0, 0, 0);
    check_eq("s6_cnt255", {24'd0, count_D1}, 32'd255);
    q1.push_back(mkword(1'b1, 1'b0));
    repeat (8) tick(100, 100, 0, 0, 0);
    check_eq("s6_wrap", {24'd0, count_D1}, 32'd0);

    // Reset while the pop is in flight
    do_reset();
    q0.push_back(6'h07);
    repeat (4) tick(100, 100, 0, 0, 2);
    repeat (4) tick(100, 100, 0, 0, 0);
    check_eq("s7_valid", {31'd0, valid_out}, 32'd0);
    check_eq("s7_cnt0", {24'd0, count_D0}, 32'd0);

    // Random traffic with backpressure, enable gaps, misroutes and stray resets
    do_reset();
    bad_en = 1'b1;
    repeat (3000) tick(80, 60, 30, 30, 3);
    bad_en = 1'b0;
    repeat (2000) tick(70, 85, 45, 20, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
